// File: rtl/mcp3008_scan_ctrl.sv
// Autonomous round-robin scan controller for the MCP3008 SPI ADC with a per-channel result file.
// Optional priority-channel interleave is enabled by defining ADC_PRIO_EN.
module mcp3008_scan_ctrl #(
  parameter int CLK_DIV     = 4,
  parameter int CS_HIGH_CYC = 16,
  parameter int PRIO_CH     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] chan_mask,
  output logic       ad_clk,
  output logic       cs,
  output logic       din,
  input  logic       dout,
  output logic       result_valid,
  output logic [2:0] result_ch,
  output logic [9:0] result_data,
  output logic       scan_done,
  input  logic [2:0] rd_ch,
  output logic [9:0] rd_data,
  output logic       busy
);

`ifdef ADC_PRIO_EN
  localparam bit PRIO_ON = 1'b1;
`else
  localparam bit PRIO_ON = 1'b0;
`endif
  localparam logic [2:0] PRIO = 3'(PRIO_CH);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [4:0]  bitn;
  logic        half;
  logic [2:0]  ch;
  logic [2:0]  rr_ptr;
  logic        prio_due;
  logic [8:0]  sr;
  logic [9:0]  rfile [8];

  logic [7:0] rr_mask;
  logic [2:0] rr_next, pick_ch, top_ch, c;
  logic       found, pick_prio, launch;

  // Command bit presented during SCLK period p: start, SGL, D2, D1, D0, then zeros.
  function automatic logic cmd_bit(input logic [4:0] p, input logic [2:0] chn);
    case (p)
      5'd0, 5'd1: cmd_bit = 1'b1;
      5'd2:       cmd_bit = chn[2];
      5'd3:       cmd_bit = chn[1];
      5'd4:       cmd_bit = chn[0];
      default:    cmd_bit = 1'b0;
    endcase
  endfunction

  always_comb begin
    rr_mask = chan_mask;
    if (PRIO_ON) rr_mask[PRIO] = 1'b0;
    rr_next = rr_ptr;
    found   = 1'b0;
    c       = '0;
    for (int i = 1; i <= 8; i++) begin
      c = rr_ptr + 3'(i);
      if (!found && rr_mask[c]) begin
        rr_next = c;
        found   = 1'b1;
      end
    end
    top_ch = '0;
    for (int i = 0; i < 8; i++)
      if (rr_mask[i]) top_ch = 3'(i);
    // Priority channel steps in after every rotation pick, or alone if nothing else is set.
    pick_prio = PRIO_ON && chan_mask[PRIO] && (prio_due || rr_mask == 8'h00);
    if (PRIO_ON && rr_mask == 8'h00) top_ch = PRIO;
    pick_ch = pick_prio ? PRIO : rr_next;
    launch  = enable && (chan_mask != 8'h00) &&
              (state == IDLE || (state == HOLD && cnt == 16'(CS_HIGH_CYC - 1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bitn         <= '0;
      half         <= 1'b0;
      ch           <= '0;
      rr_ptr       <= 3'd7;
      prio_due     <= 1'b0;
      sr           <= '0;
      cs           <= 1'b1;
      ad_clk       <= 1'b0;
      din          <= 1'b0;
      result_valid <= 1'b0;
      scan_done    <= 1'b0;
      result_ch    <= '0;
      result_data  <= '0;
      rd_data      <= '0;
      busy         <= 1'b0;
      for (int i = 0; i < 8; i++) rfile[i] <= '0;
    end else begin
      result_valid <= 1'b0;
      scan_done    <= 1'b0;
      rd_data      <= rfile[rd_ch];
      cnt          <= cnt + 16'd1;
      case (state)
        IDLE: cnt <= '0;
        SETUP:
          if (cnt == 16'(CLK_DIV - 1)) begin
            state <= SHIFT;
            cnt   <= '0;
            half  <= 1'b0;
            bitn  <= '0;
            din   <= cmd_bit(5'd0, ch);
          end
        SHIFT:
          if (cnt == 16'(CLK_DIV - 1)) begin
            cnt <= '0;
            if (!half) begin
              half   <= 1'b1;
              ad_clk <= 1'b1;
            end else begin
              half   <= 1'b0;
              ad_clk <= 1'b0;
              if (bitn >= 5'd7) sr <= {sr[7:0], dout};
              if (bitn == 5'd16) begin
                state        <= HOLD;
                cs           <= 1'b1;
                din          <= 1'b0;
                rfile[ch]    <= {sr, dout};
                result_valid <= 1'b1;
                result_ch    <= ch;
                result_data  <= {sr, dout};
                scan_done    <= (chan_mask != 8'h00) && (ch == top_ch);
              end else begin
                bitn <= bitn + 5'd1;
                din  <= cmd_bit(bitn + 5'd1, ch);
              end
            end
          end
        HOLD:
          if (cnt == 16'(CS_HIGH_CYC - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        default: state <= IDLE;
      endcase
      if (launch) begin
        state    <= SETUP;
        ch       <= pick_ch;
        cs       <= 1'b0;
        ad_clk   <= 1'b0;
        din      <= 1'b1;
        cnt      <= '0;
        busy     <= 1'b1;
        prio_due <= !pick_prio;
        if (!pick_prio) rr_ptr <= rr_next;
      end
    end
  end

endmodule
